// File: rtl/video_timing_detect.sv
`timescale 1ns/1ps
// Sync-stream timing detector: recovers active-area pixel position from hsync/vsync/de
// and measures line/frame geometry, reporting lock once consecutive frames agree.
module video_timing_detect #(
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst_pix_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        de,
  output logic [9:0]  sx,
  output logic [9:0]  sy,
  output logic        active,
  output logic        frame,
  output logic [11:0] h_total,
  output logic [11:0] h_active,
  output logic [11:0] v_total,
  output logic [11:0] v_active,
  output logic        locked
);

  localparam logic [11:0] SAT     = 12'hFFF;
  localparam logic [7:0]  MC_LAST = 8'(LOCK_FRAMES - 1);

  typedef struct packed {
    logic [11:0] h_tot;
    logic [11:0] h_act;
    logic [11:0] v_tot;
    logic [11:0] v_act;
  } dims_t;

  typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_LOCK} state_t;

  function automatic logic [11:0] inc_sat(input logic [11:0] v);
    return (v == SAT) ? v : v + 12'd1;
  endfunction

  // Sync inputs are normalised to "at active level" before the two-stage pipe.
  logic hs1, hs2, vs1, vs2, de1, de2;
  logic hs_edge, vs_edge;

  always_ff @(posedge clk or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      {hs1, hs2, vs1, vs2, de1, de2} <= '0;
    end else begin
      hs1 <= (hsync == HS_POL);
      hs2 <= hs1;
      vs1 <= (vsync == VS_POL);
      vs2 <= vs1;
      de1 <= de;
      de2 <= de1;
    end
  end

  assign hs_edge = hs1 & ~hs2;
  assign vs_edge = vs1 & ~vs2;

  logic [11:0] hcnt, hact, vcnt, vact, vcnt_l, vact_l;
  dims_t       cand, cand_n, stored, stored_n, dims, dims_n;

  // h_act only latches lines that carried video, so blanking lines just
  // before vsync do not zero the active-width candidate.
  always_comb begin
    cand_n = cand;
    vcnt_l = vcnt;
    vact_l = vact;
    if (hs_edge) begin
      cand_n.h_tot = inc_sat(hcnt);
      vcnt_l       = inc_sat(vcnt);
      if (|hact) begin
        cand_n.h_act = hact;
        vact_l       = inc_sat(vact);
      end
    end
    if (vs_edge) begin
      cand_n.v_tot = vcnt_l;
      cand_n.v_act = vact_l;
    end
  end

  always_ff @(posedge clk or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      hcnt <= '0;
      hact <= '0;
      vcnt <= '0;
      vact <= '0;
      cand <= '0;
    end else begin
      hcnt <= hs_edge ? 12'd0 : inc_sat(hcnt);
      hact <= hs_edge ? 12'd0 : (de1 ? inc_sat(hact) : hact);
      vcnt <= vs_edge ? 12'd0 : vcnt_l;
      vact <= vs_edge ? 12'd0 : vact_l;
      cand <= cand_n;
    end
  end

  state_t     state, state_n;
  logic [7:0] mcnt, mcnt_n;
  logic       wd, cand_nz;

  assign wd      = (hcnt == SAT) || (vcnt == SAT);
  assign cand_nz = (|cand_n.h_tot) && (|cand_n.h_act) && (|cand_n.v_tot) && (|cand_n.v_act);

  always_ff @(posedge clk or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state  <= ST_SEARCH;
      mcnt   <= '0;
      stored <= '0;
      dims   <= '0;
    end else begin
      state  <= state_n;
      mcnt   <= mcnt_n;
      stored <= stored_n;
      dims   <= dims_n;
    end
  end

  always_comb begin
    state_n  = state;
    mcnt_n   = mcnt;
    stored_n = stored;
    dims_n   = dims;
    if (wd) begin
      state_n  = ST_SEARCH;
      mcnt_n   = '0;
      stored_n = '0;
    end else if (vs_edge) begin
      case (state)
        ST_SEARCH: begin
          state_n = ST_MEASURE;
          mcnt_n  = '0;
        end
        ST_MEASURE: begin
          if (cand_n == stored && cand_nz) begin
            mcnt_n = mcnt + 8'd1;
            if (mcnt + 8'd1 == MC_LAST) begin
              state_n = ST_LOCK;
              dims_n  = cand_n;
            end
          end else begin
            stored_n = cand_n;
            mcnt_n   = '0;
          end
        end
        ST_LOCK: begin
          if (cand_n != dims) begin
            state_n  = ST_MEASURE;
            stored_n = cand_n;
            mcnt_n   = '0;
          end
        end
        default: state_n = ST_SEARCH;
      endcase
    end
  end

  // Position tracks the de pipe so sx/sy line up with active (de2).
  always_ff @(posedge clk or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      sx    <= '0;
      sy    <= '0;
      frame <= 1'b0;
    end else begin
      frame <= vs_edge;
      sx    <= (de1 && de2) ? sx + 10'd1 : 10'd0;
      if (vs_edge)
        sy <= '0;
      else if (de2 && !de1)
        sy <= sy + 10'd1;
    end
  end

  assign active   = de2;
  assign locked   = (state == ST_LOCK);
  assign h_total  = dims.h_tot;
  assign h_active = dims.h_act;
  assign v_total  = dims.v_tot;
  assign v_active = dims.v_act;

endmodule

// File: tb/tb_video_timing_detect.sv
`timescale 1ns/1ps
// Directed bench on a reduced raster (16x11 total, 8x6 active) so full lock
// sequences fit a short run; a second instance sees the inverted-sync stream.
module tb_video_timing_detect;

  logic clk = 1'b0;
  logic rst_pix_n = 1'b0;
  logic hs = 1'b1, vs = 1'b1, de = 1'b0;

  logic [9:0]  a_sx, a_sy, b_sx, b_sy;
  logic        a_active, a_frame, a_locked, b_active, b_frame, b_locked;
  logic [11:0] a_ht, a_ha, a_vt, a_va, b_ht, b_ha, b_vt, b_va;

  int checks = 0;
  int errors = 0;

  logic pde = 1'b0, pvs = 1'b0, ppvs = 1'b0;
  int   px = 0, py = 0;
  bit   chk_pos = 1'b0;

  always #5 clk = ~clk;

  video_timing_detect u_a (
    .clk(clk), .rst_pix_n(rst_pix_n), .hsync(hs), .vsync(vs), .de(de),
    .sx(a_sx), .sy(a_sy), .active(a_active), .frame(a_frame),
    .h_total(a_ht), .h_active(a_ha), .v_total(a_vt), .v_active(a_va),
    .locked(a_locked)
  );

  video_timing_detect #(.HS_POL(1'b1), .VS_POL(1'b1), .LOCK_FRAMES(2)) u_b (
    .clk(clk), .rst_pix_n(rst_pix_n), .hsync(~hs), .vsync(~vs), .de(de),
    .sx(b_sx), .sy(b_sy), .active(b_active), .frame(b_frame),
    .h_total(b_ht), .h_active(b_ha), .v_total(b_vt), .v_active(b_va),
    .locked(b_locked)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One pixel step; outputs observed here reflect the previous step's inputs.
  task automatic pix(input int x, input int y, input int htot);
    logic d, hsa, vsa;
    d   = (x < 8) && (y < 6);
    hsa = (x >= htot - 6) && (x < htot - 3);
    vsa = (y == 7) || (y == 8);
    hs = ~hsa;
    vs = ~vsa;
    de = d;
    @(posedge clk);
    #1;
    if (chk_pos) begin
      check("active", a_active, pde);
      check("active_inv", b_active, pde);
      check("frame", a_frame, pvs && !ppvs);
      check("frame_inv", b_frame, pvs && !ppvs);
      if (pde) begin
        check("sx", a_sx, px);
        check("sy", a_sy, py);
        check("sx_inv", b_sx, px);
        check("sy_inv", b_sy, py);
      end
    end
    ppvs = pvs;
    pvs  = vsa;
    pde  = d;
    px   = x;
    py   = y;
  endtask

  task automatic line(input int y, input int x0, input int htot);
    for (int x = x0; x < htot; x++) pix(x, y, htot);
  endtask

  task automatic frame_lock(input int htot, input logic exp_before, input logic exp_after);
    for (int y = 0; y < 7; y++) line(y, 0, htot);
    pix(0, 7, htot);
    check("locked_pre", a_locked, exp_before);
    check("locked_pre_inv", b_locked, exp_before);
    pix(1, 7, htot);
    check("locked_post", a_locked, exp_after);
    check("locked_post_inv", b_locked, exp_after);
    line(7, 2, htot);
    for (int y = 8; y < 11; y++) line(y, 0, htot);
  endtask

  task automatic check_dims(input logic [11:0] ht, input logic [11:0] ha,
                            input logic [11:0] vt, input logic [11:0] va);
    check("h_total", a_ht, ht);
    check("h_active", a_ha, ha);
    check("v_total", a_vt, vt);
    check("v_active", a_va, va);
    check("h_total_inv", b_ht, ht);
    check("h_active_inv", b_ha, ha);
    check("v_total_inv", b_vt, vt);
    check("v_active_inv", b_va, va);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_locked", a_locked, 0);
    check("rst_active", a_active, 0);
    check("rst_sx", a_sx, 0);
    check("rst_sy", a_sy, 0);
    check("rst_frame", a_frame, 0);
    check_dims(0, 0, 0, 0);
    rst_pix_n = 1'b1;

    // Lock from reset on the third vsync edge.
    frame_lock(16, 0, 0);
    frame_lock(16, 0, 0);
    frame_lock(16, 0, 1);
    check_dims(16, 8, 11, 6);

    // Position/frame alignment over a whole locked frame.
    chk_pos = 1'b1;
    frame_lock(16, 1, 1);
    chk_pos = 1'b0;

    // One frame of long lines drops lock; dims hold; relock after two clean frames.
    frame_lock(17, 1, 0);
    check_dims(16, 8, 11, 6);
    frame_lock(16, 0, 0);
    frame_lock(16, 0, 1);
    check_dims(16, 8, 11, 6);

    // Stalled sync: still locked before hcnt saturates, unlocked after.
    hs = 1'b1;
    vs = 1'b1;
    de = 1'b0;
    repeat (4000) @(posedge clk);
    #1;
    check("wd_before", a_locked, 1);
    repeat (100) @(posedge clk);
    #1;
    check("wd_after", a_locked, 0);
    check("wd_after_inv", b_locked, 0);
    check_dims(16, 8, 11, 6);
    pde = 1'b0; pvs = 1'b0; ppvs = 1'b0;
    frame_lock(16, 0, 0);
    frame_lock(16, 0, 0);
    frame_lock(16, 0, 1);
    check_dims(16, 8, 11, 6);

    // Asynchronous reset mid-line while locked.
    line(0, 0, 16);
    line(1, 0, 16);
    for (int x = 0; x < 3; x++) pix(x, 2, 16);
    check("pre_rst_active", a_active, 1);
    #2;
    rst_pix_n = 1'b0;
    #1;
    check("arst_locked", a_locked, 0);
    check("arst_active", a_active, 0);
    check("arst_sx", a_sx, 0);
    check("arst_sy", a_sy, 0);
    check("arst_frame", a_frame, 0);
    check("arst_locked_inv", b_locked, 0);
    check_dims(0, 0, 0, 0);
    @(negedge clk);
    rst_pix_n = 1'b1;
    line(2, 3, 16);
    for (int y = 3; y < 11; y++) line(y, 0, 16);
    check("relock_e1", a_locked, 0);
    frame_lock(16, 0, 0);
    frame_lock(16, 0, 1);
    check_dims(16, 8, 11, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
